// File: rtl/ghost_motion_pkg.sv
// Shared game package: direction encoding, ghost state encoding and bus widths.
package ghost_motion_pkg;

  localparam int unsigned X_W   = 11;
  localparam int unsigned Y_W   = 10;
  localparam int unsigned DIR_W = 4;

  // One-hot directions, shared with the ghost controller
  localparam logic [DIR_W-1:0] RIGHT = 4'b0001;
  localparam logic [DIR_W-1:0] UP    = 4'b0010;
  localparam logic [DIR_W-1:0] DOWN  = 4'b0100;
  localparam logic [DIR_W-1:0] LEFT  = 4'b1000;
  localparam logic [DIR_W-1:0] ZEROS = 4'b0000;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    MOVE = 2'd1,
    DEAD = 2'd2
  } ghost_state_e;

  // True when exactly one direction bit is set
  function automatic logic is_onehot_dir(input logic [DIR_W-1:0] d);
    return (d != ZEROS) && ((d & (d - DIR_W'(1))) == ZEROS);
  endfunction

endpackage

// File: rtl/tick_counter.sv
// Terminal-count tick counter used to time the ghost respawn.
module tick_counter #(
  parameter int unsigned TERMINAL = 64
) (
  input  logic clk,
  input  logic clear,
  input  logic enable,
  output logic terminal_c
);

  localparam int unsigned CNT_W = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;

  logic [CNT_W-1:0] count;

  // Pulses on the enable that completes TERMINAL counted events
  assign terminal_c = enable && (count == CNT_W'(TERMINAL - 1));

  // Count enables, wrapping to zero on the terminal event
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= terminal_c ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ghost_motion.sv
// Ghost position/direction tracker: house wait, tile-aligned steering, tunnel wrap, respawn.
module ghost_motion
  import ghost_motion_pkg::*;
#(
  parameter logic [X_W-1:0] START_X       = 11'd320,
  parameter logic [Y_W-1:0] START_Y       = 10'd240,
  parameter int unsigned    TILE          = 16,
  parameter int unsigned    STEP          = 1,
  parameter logic [X_W-1:0] X_MIN         = 11'd0,
  parameter logic [X_W-1:0] X_MAX         = 11'd624,
  parameter int unsigned    RESPAWN_TICKS = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             move_tick,
  input  logic             start,
  input  logic             caught,
  input  logic [DIR_W-1:0] move_direction,
  input  logic [DIR_W-1:0] valid_moves,
  output logic [X_W-1:0]   ghost_pos_x,
  output logic [Y_W-1:0]   ghost_pos_y,
  output logic [DIR_W-1:0] cur_direction,
  output logic             moving,
  output logic             dead
);

  ghost_state_e     state;
  logic             aligned;
  logic [DIR_W-1:0] dir_next;
  logic [DIR_W-1:0] dir_step;
  logic [X_W-1:0]   x_step;
  logic [Y_W-1:0]   y_step;
  logic             cnt_clear;
  logic             cnt_en;
  logic             respawn_c;

  // Tile alignment from the registered position (TILE is a power of two)
  assign aligned = ((ghost_pos_x & X_W'(TILE - 1)) == '0) &&
                   ((ghost_pos_y & Y_W'(TILE - 1)) == '0);

  // Steering decision and the position/direction one tick would produce
  always_comb begin
    dir_next = cur_direction;
    if (aligned) begin
      dir_next = (is_onehot_dir(move_direction) && ((move_direction & valid_moves) != ZEROS))
                 ? move_direction : ZEROS;
    end
    x_step   = ghost_pos_x;
    y_step   = ghost_pos_y;
    dir_step = dir_next;
    case (dir_next)
      RIGHT: x_step = (ghost_pos_x == X_MAX) ? X_MIN : ghost_pos_x + X_W'(STEP);
      LEFT:  x_step = (ghost_pos_x == X_MIN) ? X_MAX : ghost_pos_x - X_W'(STEP);
      DOWN:  y_step = ghost_pos_y + Y_W'(STEP);
      UP: begin
        if (ghost_pos_y == '0) dir_step = ZEROS;
        else                   y_step   = ghost_pos_y - Y_W'(STEP);
      end
      default: ;
    endcase
  end

  // Respawn timer only runs while dead and restarts from zero on every entry
  assign cnt_clear = rst || (state != DEAD);
  assign cnt_en    = move_tick && (state == DEAD);

  tick_counter #(
    .TERMINAL(RESPAWN_TICKS)
  ) u_respawn (
    .clk       (clk),
    .clear     (cnt_clear),
    .enable    (cnt_en),
    .terminal_c(respawn_c)
  );

  // Ghost FSM with registered position, direction and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= WAIT;
      ghost_pos_x   <= START_X;
      ghost_pos_y   <= START_Y;
      cur_direction <= ZEROS;
      moving        <= 1'b0;
      dead          <= 1'b0;
    end else begin
      case (state)
        WAIT: begin
          if (start) begin
            state  <= MOVE;
            moving <= 1'b1;
          end
        end
        MOVE: begin
          if (caught) begin
            state  <= DEAD;
            moving <= 1'b0;
            dead   <= 1'b1;
          end else if (move_tick) begin
            ghost_pos_x   <= x_step;
            ghost_pos_y   <= y_step;
            cur_direction <= dir_step;
          end
        end
        DEAD: begin
          if (respawn_c) begin
            state         <= WAIT;
            dead          <= 1'b0;
            ghost_pos_x   <= START_X;
            ghost_pos_y   <= START_Y;
            cur_direction <= ZEROS;
          end
        end
        default: begin
          state  <= WAIT;
          moving <= 1'b0;
          dead   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ghost_motion.sv
// Scoreboard bench for ghost_motion against a behavioural ghost model.
module tb_ghost_motion;
  import ghost_motion_pkg::*;

  localparam int M_WAIT = 0;
  localparam int M_MOVE = 1;
  localparam int M_DEAD = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        move_tick = 1'b0;
  logic        start = 1'b0;
  logic        caught = 1'b0;
  logic [3:0]  move_direction = 4'b0000;
  logic [3:0]  valid_moves = 4'b0000;
  logic [10:0] ghost_pos_x;
  logic [9:0]  ghost_pos_y;
  logic [3:0]  cur_direction;
  logic        moving;
  logic        dead;

  always #5 clk = ~clk;

  ghost_motion dut (
    .clk           (clk),
    .rst           (rst),
    .move_tick     (move_tick),
    .start         (start),
    .caught        (caught),
    .move_direction(move_direction),
    .valid_moves   (valid_moves),
    .ghost_pos_x   (ghost_pos_x),
    .ghost_pos_y   (ghost_pos_y),
    .cur_direction (cur_direction),
    .moving        (moving),
    .dead          (dead)
  );

  typedef struct {
    int       x;
    int       y;
    int       dir;
    int       mv;
    int       dd;
    int       seq;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   seq_no = 0;

  // Behavioural ghost model state
  int       m_state = M_WAIT;
  int       m_x = 320;
  int       m_y = 240;
  int       m_cnt = 0;
  logic [3:0] m_dir = 4'b0000;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // One clock of the game rules, given this cycle's inputs
  task automatic model_step(input bit r, input bit st, input bit ca, input bit tk,
                            input logic [3:0] md, input logic [3:0] vm);
    logic [3:0] nd;
    bit         al;
    if (r) begin
      m_state = M_WAIT; m_x = 320; m_y = 240; m_dir = 4'b0000; m_cnt = 0;
    end else if (m_state == M_WAIT) begin
      if (st) m_state = M_MOVE;
    end else if (m_state == M_MOVE) begin
      if (ca) begin
        m_state = M_DEAD; m_cnt = 0;
      end else if (tk) begin
        al = (m_x % 16 == 0) && (m_y % 16 == 0);
        if (!al) nd = m_dir;
        else if ($countones(md) == 1 && (md & vm) != 4'b0000) nd = md;
        else nd = 4'b0000;
        if (nd == 4'b0001) m_x = (m_x == 624) ? 0 : m_x + 1;
        else if (nd == 4'b1000) m_x = (m_x == 0) ? 624 : m_x - 1;
        else if (nd == 4'b0100) m_y = (m_y + 1) % 1024;
        else if (nd == 4'b0010) begin
          if (m_y == 0) nd = 4'b0000;
          else m_y = m_y - 1;
        end
        m_dir = nd;
      end
    end else begin
      if (tk) begin
        m_cnt++;
        if (m_cnt == 64) begin
          m_state = M_WAIT; m_x = 320; m_y = 240; m_dir = 4'b0000; m_cnt = 0;
        end
      end
    end
  endtask

  // Drive one cycle of inputs and queue the response expected after the edge
  task automatic cyc(input bit r, input bit st, input bit ca, input bit tk,
                     input logic [3:0] md, input logic [3:0] vm);
    exp_t e;
    @(negedge clk);
    rst = r; start = st; caught = ca; move_tick = tk;
    move_direction = md; valid_moves = vm;
    model_step(r, st, ca, tk, md, vm);
    e.x = m_x; e.y = m_y; e.dir = int'(m_dir);
    e.mv = (m_state == M_MOVE) ? 1 : 0;
    e.dd = (m_state == M_DEAD) ? 1 : 0;
    e.seq = seq_no++;
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic tick(input logic [3:0] md, input logic [3:0] vm);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, md, vm);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'($urandom), 4'($urandom));
  endtask

  // Monitor: compare DUT outputs with the queued expectation after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk($sformatf("sb%0d_x", e.seq), int'(ghost_pos_x), e.x);
        chk($sformatf("sb%0d_y", e.seq), int'(ghost_pos_y), e.y);
        chk($sformatf("sb%0d_dir", e.seq), int'(cur_direction), e.dir);
        chk($sformatf("sb%0d_moving", e.seq), int'(moving), e.mv);
        chk($sformatf("sb%0d_dead", e.seq), int'(dead), e.dd);
      end
    end
  end

  initial begin
    logic [3:0] md;
    int guard;

    // Reset, then ticks in WAIT with start low and other inputs noisy
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 4'b1111);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 1'($urandom), 1'b1, 4'($urandom), 4'($urandom));
      if ($urandom_range(0, 1) == 1) idle();
    end
    chk("wait_x", int'(ghost_pos_x), 320);
    chk("wait_y", int'(ghost_pos_y), 240);
    chk("wait_dir", int'(cur_direction), 0);
    chk("wait_moving", int'(moving), 0);

    // Release and walk one tile right; UP on tick 5 lands off-grid
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000);
    for (int i = 1; i <= 16; i++) tick((i == 5) ? 4'b0010 : 4'b0001, 4'b1111);
    chk("right_x", int'(ghost_pos_x), 336);
    chk("right_y", int'(ghost_pos_y), 240);
    chk("right_dir", int'(cur_direction), 1);
    chk("right_moving", int'(moving), 1);

    // Blocked UP at an aligned tile stops the ghost
    tick(4'b0010, 4'b1001);
    chk("stop_x", int'(ghost_pos_x), 336);
    chk("stop_y", int'(ghost_pos_y), 240);
    chk("stop_dir", int'(cur_direction), 0);

    // Climb to the top edge; UP at y==0 holds and stops
    for (int i = 0; i < 240; i++) tick(4'b0010, 4'b1111);
    chk("top_y", int'(ghost_pos_y), 0);
    chk("top_dir", int'(cur_direction), 2);
    tick(4'b0010, 4'b1111);
    chk("top_hold_y", int'(ghost_pos_y), 0);
    chk("top_hold_dir", int'(cur_direction), 0);

    // Left tunnel wrap
    for (int i = 0; i < 336; i++) tick(4'b1000, 4'b1111);
    chk("left_edge_x", int'(ghost_pos_x), 0);
    tick(4'b1000, 4'b1111);
    chk("wrap_left_x", int'(ghost_pos_x), 624);
    tick(4'b1000, 4'b1111);
    chk("wrap_left_next_x", int'(ghost_pos_x), 623);

    // Right tunnel wrap
    for (int i = 0; i < 15; i++) tick(4'b1000, 4'b1111);
    for (int i = 0; i < 16; i++) tick(4'b0001, 4'b1111);
    chk("right_edge_x", int'(ghost_pos_x), 624);
    tick(4'b0001, 4'b1111);
    chk("wrap_right_x", int'(ghost_pos_x), 0);
    chk("wrap_right_dir", int'(cur_direction), 1);

    // Caught with a tick in the same cycle: position held, ghost dead
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'b0001, 4'b1111);
    chk("caught_x", int'(ghost_pos_x), 0);
    chk("caught_y", int'(ghost_pos_y), 0);
    chk("caught_dead", int'(dead), 1);
    chk("caught_moving", int'(moving), 0);
    for (int i = 1; i <= 64; i++) begin
      cyc(1'b0, (i % 7) == 0, (i % 5) == 0, 1'b1, 4'($urandom), 4'($urandom));
      if (i == 63) chk("dead_63_dead", int'(dead), 1);
      if ((i % 9) == 0) idle();
    end
    chk("respawn_x", int'(ghost_pos_x), 320);
    chk("respawn_y", int'(ghost_pos_y), 240);
    chk("respawn_dir", int'(cur_direction), 0);
    chk("respawn_dead", int'(dead), 0);
    chk("respawn_moving", int'(moving), 0);

    // Randomized play
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000);
    for (int i = 0; i < 1500; i++) begin
      md = ($urandom_range(0, 3) != 0) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
      cyc(1'b0, $urandom_range(0, 19) == 0, $urandom_range(0, 199) == 0,
          $urandom_range(0, 3) != 0, md, 4'($urandom));
    end

    // Reset in the middle of DEAD
    guard = 0;
    while (m_state != M_MOVE && guard < 200) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'b0001, 4'b1111);
      guard++;
    end
    chk("reach_move", m_state, M_MOVE);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000);
    for (int i = 0; i < 20; i++) tick(4'($urandom), 4'($urandom));
    chk("middead_dead", int'(dead), 1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'b0001, 4'b1111);
    chk("rst_x", int'(ghost_pos_x), 320);
    chk("rst_y", int'(ghost_pos_y), 240);
    chk("rst_dir", int'(cur_direction), 0);
    chk("rst_moving", int'(moving), 0);
    chk("rst_dead", int'(dead), 0);

    // After reset the respawn count restarts: a fresh death needs all 64 ticks
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000);
    for (int i = 0; i < 50; i++) tick(4'b0001, 4'b1111);
    chk("recount_dead", int'(dead), 1);
    for (int i = 0; i < 14; i++) tick(4'b0001, 4'b1111);
    chk("recount_done", int'(dead), 0);

    @(negedge clk);
    rst = 1'b0; start = 1'b0; caught = 1'b0; move_tick = 1'b0;
    @(posedge clk);
    #3;
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ghost_motion.md
GHOST_MOTION -- requirements
Module: ghost_motion

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high, with ports named clk and rst.
REQ-002 Parameter START_X, default 11'd320, SHALL be the house x position.
REQ-003 Parameter START_Y, default 10'd240, SHALL be the house y position.
REQ-004 Parameter TILE, default 16, SHALL be the tile pitch in pixels (power of two).
REQ-005 Parameter STEP, default 1, SHALL be the pixels moved per tick (STEP divides TILE).
REQ-006 Parameter X_MIN, default 11'd0, SHALL be the left tunnel edge.
REQ-007 Parameter X_MAX, default 11'd624, SHALL be the right tunnel edge (a multiple of TILE).
REQ-008 Parameter RESPAWN_TICKS, default 64, SHALL be the number of ticks spent in DEAD.
REQ-009 clk  in  1  system clock.
REQ-010 rst  in  1  synchronous active-high reset.
REQ-011 move_tick  in  1  single-cycle movement strobe, sourced from the slower_clk domain edge.
REQ-012 start  in  1  pulse that releases the ghost from the house.
REQ-013 caught  in  1  pulse indicating a collision with pacman.
REQ-014 move_direction  in  4  one-hot requested direction from the ghost controller (RIGHT=0001, UP=0010, DOWN=0100, LEFT=1000).
REQ-015 valid_moves  in  4  one-hot mask of open directions at the current position.
REQ-016 ghost_pos_x  out  11  registered x position.
REQ-017 ghost_pos_y  out  10  registered y position.
REQ-018 cur_direction  out  4  registered direction last applied, fed back to the controller as prev_direction.
REQ-019 moving  out  1  high in MOVE.
REQ-020 dead  out  1  high in DEAD.

Function
REQ-021 The FSM SHALL have three states: WAIT, MOVE and DEAD.
REQ-022 WAIT SHALL transition to MOVE on start; all other inputs are ignored in WAIT.
REQ-023 MOVE SHALL transition to DEAD on caught; caught takes priority over a move_tick in the same cycle, and the position is held.
REQ-024 DEAD SHALL count move_ticks; on tick number RESPAWN_TICKS it loads START_X/START_Y, sets cur_direction to 0000 and enters WAIT; caught and start are ignored in DEAD.
REQ-025 aligned SHALL be defined as x mod TILE == 0 and y mod TILE == 0, computed on the registered position.
REQ-026 On a move_tick in MOVE with aligned true, dir_next SHALL be move_direction if it is exactly one-hot and that bit is set in valid_moves; otherwise dir_next SHALL be 0000 (stop).
REQ-027 On a move_tick in MOVE with aligned false, dir_next SHALL be cur_direction, and move_direction and valid_moves are ignored.
REQ-028 On each MOVE tick, the position SHALL move STEP pixels in dir_next (RIGHT +x, LEFT -x, DOWN +y, UP -y), and cur_direction SHALL take dir_next.
REQ-029 Latency SHALL be one cycle: the outputs update in the cycle after the move_tick cycle; with no tick, all outputs hold.
REQ-030 Wrap-around: LEFT at x==X_MIN SHALL load X_MAX, and RIGHT at x==X_MAX SHALL load X_MIN; no other step is applied in that tick.
REQ-031 Y edge: UP at y==0 SHALL hold position and set cur_direction to 0000; there is no vertical wrap.
REQ-032 A stopped ghost (cur_direction 0000) SHALL re-evaluate per REQ-026 on every subsequent tick.
REQ-033 moving and dead SHALL be decoded from registered state only.

Reset
REQ-034 On rst, the block SHALL set state WAIT, ghost_pos_x=START_X, ghost_pos_y=START_Y, cur_direction=0000, respawn counter=0, moving=0 and dead=0.
REQ-035 rst SHALL override all other inputs in the same cycle, including a mid-move or mid-DEAD reset.

Structure
REQ-036 The direction constants (RIGHT, LEFT, UP, DOWN, ZEROS) and the state encoding SHALL live in the shared game package, also used by ghost_control.
REQ-037 The respawn counter SHALL be the sub-module tick_counter (enable, clear, terminal count output).

Verification
REQ-038 The bench SHALL apply rst, then hold start=0 for 10 ticks, and require pos=(320,240), cur_direction=0000 and moving=0.
REQ-039 The bench SHALL apply start, then 16 ticks with move_direction=RIGHT and valid_moves=1111, and require x=336, cur_direction=RIGHT; on tick 5, move_direction=UP is ignored because the ghost is not aligned.
REQ-040 The bench SHALL apply, at aligned (336,240), move_direction=UP with valid_moves=1001, and require a stop: pos unchanged and cur_direction=0000.
REQ-041 The bench SHALL apply LEFT ticks from x=0, and require x=624 after the tick and x=623 after the next tick.
REQ-042 The bench SHALL apply caught and move_tick in the same cycle, and require pos held and dead=1; after 64 ticks, pos=(320,240) and state WAIT; a caught during DEAD is ignored.
REQ-043 The bench SHALL apply rst mid-DEAD, and require all REQ-034 values on the next cycle.
